uart_axi_lite_master: RTL and testbench
=======================================

# uart_axi_lite_master

UART-driven AXI4-Lite initiator: the host-side counterpart of the SoC's UART peripheral. It receives command frames on `rx` (8N1), turns each into a single 32-bit AXI4-Lite read or write, and returns a status/data frame on `tx`. It sits as an extra crossbar master, behind an AXI-Lite to AXI up-converter, and serves as a debug/loader port on targets without JTAG.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `AXI_ADDR_WIDTH`, 64, AXI address width; the 32-bit frame address is zero-extended.
- `TIMEOUT_CYCLES`, 16·CLKS_PER_BIT·10, maximum idle gap between bytes of one frame.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `rx`, in, 1: UART receive, asynchronous, idle high.
- `tx`, out, 1: UART transmit, idle high.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `aw_addr` out AXI_ADDR_WIDTH, `aw_valid` out 1, `aw_ready` in 1.
- `w_data` out 32, `w_strb` out 4, `w_valid` out 1, `w_ready` in 1.
- `b_resp` in 2, `b_valid` in 1, `b_ready` out 1.
- `ar_addr` out AXI_ADDR_WIDTH, `ar_valid` out 1, `ar_ready` in 1.
- `r_data` in 32, `r_resp` in 2, `r_valid` in 1, `r_ready` out 1.
- `aw_prot` and `ar_prot` are tied to 0 by the integrator.

## Operation
- **UART RX**
  - `rx` passes through a 2-flop synchronizer.
  - Start bit: a falling edge in RX idle. The line is resampled at CLKS_PER_BIT/2; if it is high, the start was false and RX returns to idle.
  - Data bits: sampled every CLKS_PER_BIT, LSB first.
  - Stop bit: sampled after the data bits. If low, this is a framing error: the byte is discarded and any partial frame is aborted with no response. RX then waits for the line to go high.
- **UART TX**: 8N1, LSB first. Each bit is held for exactly CLKS_PER_BIT cycles.
- **Command frame** (bytes little-endian)
  - Write: 0x57, then ADDR[4], then DATA[4].
  - Read: 0x52, then ADDR[4].
  - Any other first byte: reply 0xEE and return to IDLE.
- **Response frame**
  - Write: one byte, 0xA0 | BRESP.
  - Read: 0xA0 | RRESP, followed by RDATA[4], little-endian.
- **FSM states**
  - IDLE: first byte → GET_ADDR, or SEND_ERR on a bad opcode.
  - GET_ADDR: after 4 bytes → GET_DATA (write) or AXI_RD (read).
  - GET_DATA: after 4 bytes → AXI_WR.
  - AXI_WR → SEND_RESP.
  - AXI_RD → SEND_RESP.
  - SEND_RESP / SEND_ERR → IDLE after the last stop bit.
- **AXI_WR**
  - `aw_valid` and `w_valid` assert together.
  - Each valid drops independently on its own handshake.
  - `b_ready` asserts once both handshakes are done and holds until `b_valid`.
  - `w_strb` = 4'hF.
- **AXI_RD**: `ar_valid` holds until `ar_ready`. `r_ready` then holds until `r_valid`. `r_data`/`r_resp` are captured on that handshake.
- **Outputs**: addresses and write data are registered. They are stable while the corresponding valid is high.
- **Bytes outside a frame**: bytes received in AXI_*/SEND_* states are dropped. RX keeps running so it stays bit-aligned.
- **Timeout**: in GET_ADDR/GET_DATA, the gap counter resets on every accepted byte. When it reaches TIMEOUT_CYCLES, the frame is aborted silently and the FSM returns to IDLE.
- **No AXI timeout**: a stalled slave holds the FSM in AXI_*.

## Timing
- **Reset values**: `tx`=1, `busy`=0, all valids/readies 0, addr/data registers 0, FSM=IDLE, RX/TX idle.
- **Reset mid-operation**: all outstanding AXI and UART activity is abandoned. The integrator guarantees crossbar reset is applied concurrently.
- **Byte accept**: a byte is accepted in the cycle after the stop-bit sample.
- **Into AXI states**: `aw_valid`/`w_valid` (or `ar_valid`) rise 1 cycle after the last frame byte is accepted.
- **Single-cycle channel**: a ready high in the same cycle as the valid rises completes the handshake in 1 cycle. Valid is low on the next cycle.
- **Response start**: the response start bit begins 1 cycle after the B/R handshake. Consecutive response bytes have no idle gap between the stop bit and the next start bit.
- **Simultaneous `aw_ready` and `w_ready`**: both channels complete in one cycle, and `b_ready` rises the next cycle.
- **Early `b_valid`**: a `b_valid` arriving before both handshakes is not accepted until `b_ready` rises.
- **`busy`**: rises 1 cycle after the opcode byte is accepted. It falls on the cycle the FSM returns to IDLE.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- **Write**: send 57 00 10 00 80 EF BE AD DE.
  - One AW with `aw_addr`=0x80001000 and one W with `w_data`=0xDEADBEEF, `w_strb`=F.
  - `b_resp`=0 → `tx` byte 0xA0.
- **Read**: send 52 04 00 00 80; slave returns `r_data`=0x12345678, `r_resp`=0.
  - One AR with `ar_addr`=0x80000004.
  - `tx` bytes A0 78 56 34 12, sent back-to-back.
- **Backpressure/error**: write with `aw_ready` delayed 5 cycles, `w_ready` immediate, `b_resp`=2.
  - `w_valid` is high for 1 cycle; `aw_valid` is high for 6 cycles.
  - Exactly one B handshake; `tx` byte 0xA2.
- **Bad opcode**: send 0x33 → `tx` byte 0xEE, no AXI valid, `busy` low afterwards. A following valid read completes normally.
- **Framing/timeout**
  - Read frame whose 3rd byte has stop bit=0 → no AXI activity, no `tx` activity.
  - Write frame stopped after 3 bytes → after TIMEOUT_CYCLES, `busy`=0. The next full frame works.
- **Reset mid-transfer**: assert `rst_n`=0 for 1 cycle while `ar_valid`=1 → the next cycle shows all valids 0, `tx`=1, `busy`=0.

Source files
------------

// File: rtl/uart_axi_lite_master.sv
// uart_axi_lite_master
//   UART (8N1) command port that issues single 32-bit AXI4-Lite reads/writes.
//   Write frame: 0x57 ADDR[4] DATA[4] -> reply 0xA0|BRESP
//   Read frame:  0x52 ADDR[4]         -> reply 0xA0|RRESP RDATA[4]
//   Any other opcode                  -> reply 0xEE
// Ports:
//   clk, rst_n (sync, active-low), rx/tx (UART, idle high), busy (FSM not IDLE)
//   AW/W/B and AR/R AXI4-Lite master channels; addresses zero-extended.
module uart_axi_lite_master #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 16 * CLKS_PER_BIT * 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic                      tx,
    output logic                      busy,
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [31:0]               w_data,
    output logic [3:0]                w_strb,
    output logic                      w_valid,
    input  logic                      w_ready,
    input  logic [1:0]                b_resp,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [31:0]               r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_valid,
    output logic                      r_ready
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, AXI_WR, AXI_RD, SEND_RESP, SEND_ERR} state_t;

    logic            rx_s1_q, rx_s2_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_vld_q, rx_vld_d, rx_ferr_q, rx_ferr_d;

    logic [9:0]      tx_sh_q, tx_sh_d;
    logic [3:0]      tx_bits_q, tx_bits_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic            tx_busy, tx_ready, tx_load;
    logic [7:0]      tx_byte;

    state_t          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
    logic [2:0]      resp_left_q, resp_left_d;
    logic            aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
    logic            ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic            hs_aw, hs_w;

    // UART receiver: start validated at mid-bit, data/stop sampled at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_vld_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s2_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                if (rx_s2_q) begin
                    rx_vld_d   = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_ferr_d  = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            RX_WAIT_HIGH: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // UART transmitter. A new byte may be loaded on the last cycle of the
    // current stop bit so consecutive response bytes run without a gap.
    assign tx_busy  = (tx_bits_q != 4'd0);
    assign tx_ready = !tx_busy || (tx_bits_q == 4'd1 && tx_cnt_q == BIT_LAST);
    assign tx       = tx_busy ? tx_sh_q[0] : 1'b1;

    always_comb begin
        tx_sh_d   = tx_sh_q;
        tx_bits_d = tx_bits_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_busy) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d  = '0;
                tx_bits_d = tx_bits_q - 1'b1;
                tx_sh_d   = {1'b1, tx_sh_q[9:1]};
            end else tx_cnt_d = tx_cnt_q + 1'b1;
        end
        if (tx_load) begin
            tx_sh_d   = {1'b1, tx_byte, 1'b0};
            tx_bits_d = 4'd10;
            tx_cnt_d  = '0;
        end
    end

    assign hs_aw = aw_valid_q && aw_ready;
    assign hs_w  = w_valid_q && w_ready;

    // Command FSM
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        case (state_q)
            IDLE: if (rx_vld_q) begin
                byte_cnt_d = '0;
                to_cnt_d   = '0;
                if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
                    is_wr_d = (rx_sh_q == 8'h57);
                    state_d = GET_ADDR;
                end else begin
                    tx_load = 1'b1;
                    tx_byte = 8'hEE;
                    state_d = SEND_ERR;
                end
            end
            GET_ADDR, GET_DATA: begin
                if (rx_ferr_q) begin
                    state_d = IDLE;
                end else if (rx_vld_q) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (state_q == GET_ADDR) addr_d  = {rx_sh_q, addr_q[31:8]};
                    else                     wdata_d = {rx_sh_q, wdata_q[31:8]};
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == GET_DATA) begin
                            state_d    = AXI_WR;
                            aw_valid_d = 1'b1;
                            w_valid_d  = 1'b1;
                            aw_done_d  = 1'b0;
                            w_done_d   = 1'b0;
                        end else if (is_wr_q) begin
                            state_d = GET_DATA;
                        end else begin
                            state_d    = AXI_RD;
                            ar_valid_d = 1'b1;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            AXI_WR: begin
                if (hs_aw) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (hs_w) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q || hs_aw) && (w_done_q || hs_w)) b_ready_d = 1'b1;
                // Response byte is loaded on the handshake so the start bit follows next cycle.
                if (b_ready_q && b_valid) begin
                    b_ready_d   = 1'b0;
                    tx_load     = 1'b1;
                    tx_byte     = {6'b101000, b_resp};
                    resp_left_d = 3'd0;
                    state_d     = SEND_RESP;
                end
            end
            AXI_RD: begin
                if (ar_valid_q && ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
                if (r_ready_q && r_valid) begin
                    r_ready_d   = 1'b0;
                    resp_d      = r_data;
                    resp_left_d = 3'd4;
                    tx_load     = 1'b1;
                    tx_byte     = {6'b101000, r_resp};
                    state_d     = SEND_RESP;
                end
            end
            SEND_RESP: begin
                if (resp_left_q != 3'd0) begin
                    if (tx_ready) begin
                        tx_load     = 1'b1;
                        tx_byte     = resp_q[7:0];
                        resp_d      = {8'h00, resp_q[31:8]};
                        resp_left_d = resp_left_q - 1'b1;
                    end
                end else if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            SEND_ERR: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_vld_q    <= 1'b0;
            rx_ferr_q   <= 1'b0;
            tx_sh_q     <= '1;
            tx_bits_q   <= '0;
            tx_cnt_q    <= '0;
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_vld_q    <= rx_vld_d;
            rx_ferr_q   <= rx_ferr_d;
            tx_sh_q     <= tx_sh_d;
            tx_bits_q   <= tx_bits_d;
            tx_cnt_q    <= tx_cnt_d;
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign aw_addr  = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr_q};
    assign ar_addr  = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr_q};
    assign w_data   = wdata_q;
    assign w_strb   = 4'hF;
    assign aw_valid = aw_valid_q;
    assign w_valid  = w_valid_q;
    assign b_ready  = b_ready_q;
    assign ar_valid = ar_valid_q;
    assign r_ready  = r_ready_q;

endmodule

// File: tb/tb_uart_axi_lite_master.sv
// Directed bench for uart_axi_lite_master with CLKS_PER_BIT=8.
module tb_uart_axi_lite_master;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx, busy;
    logic [63:0] aw_addr, ar_addr;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic        b_valid = 1'b0, r_valid = 1'b0;
    logic [1:0]  b_resp = 2'd0, r_resp = 2'd0;
    logic [31:0] w_data, r_data = 32'd0;
    logic [3:0]  w_strb;

    uart_axi_lite_master #(.CLKS_PER_BIT(CPB), .AXI_ADDR_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .busy(busy),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AXI slave model
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
    logic [31:0] rdata_cfg = 32'd0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0;
    logic [63:0] aw_seen = '0, ar_seen = '0;
    logic [31:0] w_seen = '0;
    logic [3:0]  strb_seen = '0;
    longint      r_hs_t = 0;

    always @(negedge clk) begin
        if (aw_valid) begin aw_ready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin aw_ready = 1'b0; aw_cnt = 0; end
        if (w_valid) begin w_ready = (w_cnt >= w_delay); w_cnt++; end
        else begin w_ready = 1'b0; w_cnt = 0; end
        if (ar_valid) begin ar_ready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin ar_ready = 1'b0; ar_cnt = 0; end
        b_valid = (b_hs < aw_hs) && (b_hs < w_hs);
        b_resp  = bresp_cfg;
        r_valid = (r_hs < ar_hs);
        r_data  = rdata_cfg;
        r_resp  = rresp_cfg;
    end

    always @(posedge clk) begin
        if (aw_valid) aw_hi++;
        if (w_valid) w_hi++;
        if (ar_valid) ar_hi++;
        if (aw_valid && aw_ready) begin aw_hs++; aw_seen = aw_addr; end
        if (w_valid && w_ready) begin w_hs++; w_seen = w_data; strb_seen = w_strb; end
        if (b_valid && b_ready) b_hs++;
        if (ar_valid && ar_ready) begin ar_hs++; ar_seen = ar_addr; end
        if (r_valid && r_ready) begin r_hs++; r_hs_t = $time; end
    end

    // UART TX monitor: records each byte and the time its start bit was seen.
    logic [7:0] txq[$];
    longint     txst[$];

    initial begin
        logic [7:0] b;
        longint     st;
        forever begin
            @(posedge clk);
            if (tx == 1'b0) begin
                st = $time;
                repeat (CPB / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                txq.push_back(b);
                txst.push_back(st);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i], 1'b0);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_nbytes"}, 64'(txq.size()), 64'(n));
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int          tb0, aw0, w0, b0, ar0, r0, awh0, wh0, arh0, k;
        logic [7:0]  frm[$];
        logic [7:0]  exp[$];

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 0);
        chk("rst_addr", aw_addr, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain write, both channels ready immediately
        tb0 = txq.size(); aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awh0 = aw_hi; wh0 = w_hi;
        frm = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(frm);
        wait_bytes(tb0 + 1, "wr");
        chk("wr_aw_hs", 64'(aw_hs - aw0), 1);
        chk("wr_w_hs", 64'(w_hs - w0), 1);
        chk("wr_b_hs", 64'(b_hs - b0), 1);
        chk("wr_addr", aw_seen, 64'h80001000);
        chk("wr_data", w_seen, 32'hDEADBEEF);
        chk("wr_strb", strb_seen, 4'hF);
        chk("wr_aw_cycles", 64'(aw_hi - awh0), 1);
        chk("wr_w_cycles", 64'(w_hi - wh0), 1);
        chk("wr_resp", txq[tb0], 8'hA0);
        chk("wr_busy", busy, 0);

        // Read: five back-to-back response bytes
        tb0 = txq.size(); ar0 = ar_hs; r0 = r_hs;
        rdata_cfg = 32'h12345678;
        frm = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
        send_frame(frm);
        wait_bytes(tb0 + 5, "rd");
        chk("rd_ar_hs", 64'(ar_hs - ar0), 1);
        chk("rd_r_hs", 64'(r_hs - r0), 1);
        chk("rd_addr", ar_seen, 64'h80000004);
        exp = '{8'hA0, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (exp[i]) chk($sformatf("rd_byte%0d", i), txq[tb0 + i], exp[i]);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rd_gap%0d", i), 64'(txst[tb0 + i + 1] - txst[tb0 + i]), 64'(10 * CPB * 10));
        chk("rd_resp_lat", 64'(txst[tb0] - r_hs_t), 10);
        chk("rd_busy", busy, 0);

        // Write with AW backpressure and SLVERR
        tb0 = txq.size(); b0 = b_hs; awh0 = aw_hi; wh0 = w_hi;
        aw_delay = 5; bresp_cfg = 2'd2;
        frm = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(frm);
        wait_bytes(tb0 + 1, "bp");
        chk("bp_aw_cycles", 64'(aw_hi - awh0), 6);
        chk("bp_w_cycles", 64'(w_hi - wh0), 1);
        chk("bp_b_hs", 64'(b_hs - b0), 1);
        chk("bp_data", w_seen, 32'h44332211);
        chk("bp_resp", txq[tb0], 8'hA2);
        aw_delay = 0; bresp_cfg = 2'd0;

        // Bad opcode, then a normal read
        tb0 = txq.size(); awh0 = aw_hi; wh0 = w_hi; arh0 = ar_hi;
        send_byte(8'h33, 1'b0);
        wait_bytes(tb0 + 1, "bad");
        chk("bad_resp", txq[tb0], 8'hEE);
        chk("bad_no_axi", 64'((aw_hi - awh0) + (w_hi - wh0) + (ar_hi - arh0)), 0);
        chk("bad_busy", busy, 0);
        tb0 = txq.size();
        rdata_cfg = 32'hCAFEF00D;
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
        send_frame(frm);
        wait_bytes(tb0 + 5, "rd2");
        chk("rd2_addr", ar_seen, 64'h80000008);
        exp = '{8'hA0, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        foreach (exp[i]) chk($sformatf("rd2_byte%0d", i), txq[tb0 + i], exp[i]);

        // Framing error on the third byte aborts silently
        tb0 = txq.size(); arh0 = ar_hi;
        send_byte(8'h52, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (400) @(negedge clk);
        chk("fe_no_tx", 64'(txq.size() - tb0), 0);
        chk("fe_no_ar", 64'(ar_hi - arh0), 0);
        chk("fe_busy", busy, 0);

        // Inter-byte timeout, then a full write recovers
        tb0 = txq.size(); awh0 = aw_hi;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        repeat (1000) @(negedge clk);
        chk("to_busy_hold", busy, 1);
        repeat (400) @(negedge clk);
        chk("to_busy_drop", busy, 0);
        chk("to_no_aw", 64'(aw_hi - awh0), 0);
        frm = '{8'h57, 8'h0C, 8'h00, 8'h00, 8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(frm);
        wait_bytes(tb0 + 1, "to_wr");
        chk("to_wr_addr", aw_seen, 64'h8000000C);
        chk("to_wr_data", w_seen, 32'h12345678);
        chk("to_wr_resp", txq[tb0], 8'hA0);

        // Reset while AR is stalled
        ar_delay = 100000;
        frm = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h80};
        send_frame(frm);
        k = 0;
        while (!ar_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_arv_seen", ar_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 0);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        ar_delay = 0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
